// File: rtl/tick_pkg.sv
// Shared types for the multi-channel tick generator: channel mode and FSM state.
package tick_pkg;

  typedef enum logic {
    TICK_PERIODIC = 1'b0,
    TICK_ONESHOT  = 1'b1
  } tick_mode_t;

  typedef enum logic {
    CH_IDLE,
    CH_RUN
  } ch_state_t;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: IDLE/RUN FSM, counter and latched period/mode.
// Emits a registered one-cycle tick every period+1 enabled cycles.
module tick_channel
  import tick_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  ch_state_t        state_reg,  state_next;
  tick_mode_t       mode_reg,   mode_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic [WIDTH-1:0] count_reg,  count_next;
  logic             tick_reg,   tick_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= CH_IDLE;
      mode_reg   <= TICK_PERIODIC;
      period_reg <= '0;
      count_reg  <= '0;
      tick_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      period_reg <= period_next;
      count_reg  <= count_next;
      tick_reg   <= tick_next;
    end
  end

  // stop outranks start; a restart never ticks, even on an old terminal match
  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    period_next = period_reg;
    count_next  = count_reg;
    tick_next   = 1'b0;
    if (stop) begin
      state_next = CH_IDLE;
      count_next = '0;
    end else if (start) begin
      state_next  = CH_RUN;
      count_next  = '0;
      period_next = period;
      mode_next   = tick_mode_t'(mode);
    end else if (state_reg == CH_RUN && en) begin
      if (count_reg == period_reg) begin
        count_next = '0;
        tick_next  = 1'b1;
        if (mode_reg == TICK_ONESHOT) begin
          state_next = CH_IDLE;
        end
      end else begin
        count_next = count_reg + 1'b1;
      end
    end
  end

  assign tick  = tick_reg;
  assign busy  = (state_reg == CH_RUN);
  assign count = count_reg;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator; each channel is an independent
// tick_channel, this level only slices the per-channel ports.
module tick_gen
  import tick_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic                          en,
  input  logic [NUM_CH-1:0]             start,
  input  logic [NUM_CH-1:0]             stop,
  input  logic [NUM_CH-1:0]             mode,
  input  logic [NUM_CH-1:0][WIDTH-1:0]  period,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             busy,
  output logic [NUM_CH-1:0][WIDTH-1:0]  count
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      tick_channel #(
        .WIDTH(WIDTH)
      ) u_ch (
        .clk    (clk),
        .rst    (RST),
        .en     (en),
        .start  (start[gi]),
        .stop   (stop[gi]),
        .mode   (mode[gi]),
        .period (period[gi]),
        .tick   (tick[gi]),
        .busy   (busy[gi]),
        .count  (count[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: elapsed-cycle reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_tick_gen;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;

  logic                         clk = 1'b0;
  logic                         rst = 1'b0;
  logic                         en = 1'b0;
  logic [NUM_CH-1:0]            start = '0;
  logic [NUM_CH-1:0]            stop = '0;
  logic [NUM_CH-1:0]            mode = '0;
  logic [NUM_CH-1:0][WIDTH-1:0] period = '0;
  logic [NUM_CH-1:0]            tick;
  logic [NUM_CH-1:0]            busy;
  logic [NUM_CH-1:0][WIDTH-1:0] count;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  tick_gen #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk(clk), .RST(rst), .en(en), .start(start), .stop(stop),
    .mode(mode), .period(period), .tick(tick), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: a channel has run for m_el enabled cycles since start;
  // count is m_el mod (P+1), and a tick marks each completed multiple of P+1.
  bit      m_run  [NUM_CH];
  bit      m_os   [NUM_CH];
  int      m_p    [NUM_CH];
  int      m_el   [NUM_CH];
  bit      m_tick [NUM_CH];

  always @(posedge clk or posedge rst) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        m_run[c] = 0; m_os[c] = 0; m_p[c] = 0; m_el[c] = 0; m_tick[c] = 0;
      end else begin
        m_tick[c] = 0;
        if (stop[c]) begin
          m_run[c] = 0; m_el[c] = 0;
        end else if (start[c]) begin
          m_run[c] = 1; m_el[c] = 0; m_p[c] = int'(period[c]); m_os[c] = mode[c];
        end else if (m_run[c] && en) begin
          m_el[c] = m_el[c] + 1;
          if (m_el[c] % (m_p[c] + 1) == 0) begin
            m_tick[c] = 1;
            if (m_os[c]) begin
              m_run[c] = 0; m_el[c] = 0;
            end
          end
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      logic [NUM_CH-1:0]            e_tick;
      logic [NUM_CH-1:0]            e_busy;
      logic [NUM_CH-1:0][WIDTH-1:0] e_cnt;
      for (int c = 0; c < NUM_CH; c++) begin
        e_tick[c] = m_tick[c];
        e_busy[c] = m_run[c];
        e_cnt[c]  = m_run[c] ? WIDTH'(m_el[c] % (m_p[c] + 1)) : '0;
      end
      cmp("model_tick", 64'(tick), 64'(e_tick));
      cmp("model_busy", 64'(busy), 64'(e_busy));
      cmp("model_count", 64'(count), 64'(e_cnt));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic kick(input int ch, input int p, input bit os);
    start[ch] = 1'b1; period[ch] = WIDTH'(p); mode[ch] = os;
    step();
    start[ch] = 1'b0;
  endtask

  initial begin
    int ec1 [12];
    int et1 [12];
    int ec3 [8];
    int et3 [8];
    bit en3 [8];
    ec1 = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    et1 = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    ec3 = '{1, 2, 2, 2, 3, 0, 1, 2};
    et3 = '{0, 0, 0, 0, 0, 1, 0, 0};
    en3 = '{1, 1, 0, 0, 1, 1, 1, 1};

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;
    cmp("reset_tick", 64'(tick), 64'd0);
    cmp("reset_busy", 64'(busy), 64'd0);
    cmp("reset_count", 64'(count), 64'd0);

    // periodic ch0, period 3
    en = 1'b1;
    kick(0, 3, 1'b0);
    cmp("p3_busy_e0", 64'(busy[0]), 64'd1);
    cmp("p3_count_e0", 64'(count[0]), 64'd0);
    for (int k = 0; k < 12; k++) begin
      step();
      cmp($sformatf("p3_count_e%0d", k + 1), 64'(count[0]), 64'(ec1[k]));
      cmp($sformatf("p3_tick_e%0d", k + 1), 64'(tick[0]), 64'(et1[k]));
      cmp($sformatf("p3_busy_e%0d", k + 1), 64'(busy[0]), 64'd1);
    end

    // one-shot ch1, period 5
    kick(1, 5, 1'b1);
    for (int k = 1; k <= 26; k++) begin
      step();
      cmp($sformatf("os5_tick_e%0d", k), 64'(tick[1]), (k == 6) ? 64'd1 : 64'd0);
      cmp($sformatf("os5_busy_e%0d", k), 64'(busy[1]), (k < 6) ? 64'd1 : 64'd0);
    end

    stop[0] = 1'b1; step(); stop[0] = 1'b0;
    cmp("stop0_busy", 64'(busy[0]), 64'd0);
    cmp("stop0_count", 64'(count[0]), 64'd0);

    // pause: en low for edges 3 and 4
    kick(0, 3, 1'b0);
    for (int k = 0; k < 8; k++) begin
      en = en3[k];
      step();
      cmp($sformatf("pause_count_e%0d", k + 1), 64'(count[0]), 64'(ec3[k]));
      cmp($sformatf("pause_tick_e%0d", k + 1), 64'(tick[0]), 64'(et3[k]));
    end
    en = 1'b1;
    stop[0] = 1'b1; step(); stop[0] = 1'b0;

    // restart ch2 at count 2 of period 7 with new period 1
    kick(2, 7, 1'b0);
    step(); step();
    cmp("rs_count_pre", 64'(count[2]), 64'd2);
    kick(2, 1, 1'b0);
    cmp("rs_count_e0", 64'(count[2]), 64'd0);
    cmp("rs_tick_e0", 64'(tick[2]), 64'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      cmp($sformatf("rs_tick_e%0d", k), 64'(tick[2]), (k % 2 == 0) ? 64'd1 : 64'd0);
      cmp($sformatf("rs_count_e%0d", k), 64'(count[2]), 64'(k % 2));
    end
    start[2] = 1'b1; stop[2] = 1'b1; step(); start[2] = 1'b0; stop[2] = 1'b0;
    cmp("ss_busy", 64'(busy[2]), 64'd0);
    cmp("ss_count", 64'(count[2]), 64'd0);

    // period 0 periodic, then one-shot
    kick(3, 0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      cmp($sformatf("p0_tick_e%0d", k), 64'(tick[3]), 64'd1);
    end
    stop[3] = 1'b1; step(); stop[3] = 1'b0;
    kick(3, 0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      step();
      cmp($sformatf("p0os_tick_e%0d", k), 64'(tick[3]), (k == 1) ? 64'd1 : 64'd0);
      cmp($sformatf("p0os_busy_e%0d", k), 64'(busy[3]), 64'd0);
    end

    // period 255 at WIDTH 8
    kick(3, 255, 1'b0);
    for (int k = 1; k <= 257; k++) begin
      step();
      if (k == 255) cmp("p255_count_e255", 64'(count[3]), 64'd255);
      if (k >= 254) begin
        cmp($sformatf("p255_tick_e%0d", k), 64'(tick[3]), (k == 256) ? 64'd1 : 64'd0);
      end
    end
    cmp("p255_count_e257", 64'(count[3]), 64'd1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 99) < 85);
      for (int c = 0; c < NUM_CH; c++) begin
        start[c] = ($urandom_range(0, 15) == 0);
        stop[c]  = ($urandom_range(0, 49) == 0);
        mode[c]  = $urandom_range(0, 1);
        case ($urandom_range(0, 9))
          0:       period[c] = '0;
          1:       period[c] = WIDTH'($urandom_range(200, 255));
          default: period[c] = WIDTH'($urandom_range(1, 12));
        endcase
      end
      step();
    end
    start = '0; stop = '0; en = 1'b1;

    // asynchronous reset mid-run
    for (int c = 0; c < NUM_CH; c++) begin
      start[c] = 1'b1; period[c] = WIDTH'(10 + c); mode[c] = 1'b0;
    end
    step();
    start = '0;
    repeat (3) step();
    cmp("pre_rst_busy", 64'(busy), 64'hF);
    #2 rst = 1'b1;
    #1;
    cmp("async_rst_tick", 64'(tick), 64'd0);
    cmp("async_rst_busy", 64'(busy), 64'd0);
    cmp("async_rst_count", 64'(count), 64'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      cmp("post_rst_tick", 64'(tick), 64'd0);
      cmp("post_rst_busy", 64'(busy), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
# tick_gen

Multi-channel programmable tick generator: the parametrised successor of the single free-running compare counter. Each channel holds a latched period, runs in periodic or one-shot mode, can be started, stopped and paused, and emits a registered one-cycle tick every PERIOD+1 enabled cycles. It sits between the game controller and the timing consumers (piece-drop animation, cursor blink, LED scan refresh). One channel is allocated per consumer.

## Interface
- NUM_CH, 4: number of independent channels, ≥1.
- WIDTH, 32: counter and period width in bits, ≥2.
- clk  in  1  system clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when low, all channels pause.
- start  in  NUM_CH  per-channel start/restart pulse.
- stop  in  NUM_CH  per-channel stop pulse.
- mode  in  NUM_CH  per-channel mode, sampled at start; 0 = periodic, 1 = one-shot.
- period  in  [NUM_CH-1:0][WIDTH-1:0]  per-channel terminal count, sampled at start.
- tick  out  NUM_CH  registered one-cycle pulse at terminal count.
- busy  out  NUM_CH  channel is in RUN.
- count  out  [NUM_CH-1:0][WIDTH-1:0]  current per-channel count.

## Operation
- Per-channel FSM, states IDLE and RUN; channels are fully independent.
- IDLE: count held at 0, tick 0. A start moves the channel to RUN, clears count to 0, and latches period and mode.
- RUN with en=1:
  - If count == latched period: count ← 0 and tick ← 1. In one-shot mode the channel also goes to IDLE.
  - Otherwise count ← count+1 and tick ← 0.
- RUN with en=0: count, state and latched values are held; tick ← 0.
- start while in RUN: restart. count ← 0, new period and mode are latched, and no tick is produced that cycle even if the old terminal count matched.
- stop: the channel goes to IDLE with count ← 0 and tick ← 0, whatever the state.
- stop and start on the same edge: stop wins.
- start is honoured regardless of en. Counting begins at the first enabled edge.
- period = 0:
  - Periodic mode ticks on every enabled cycle; tick stays high continuously.
  - One-shot mode ticks once, on the first enabled edge after start.
- Arithmetic is unsigned WIDTH bits. count never exceeds the latched period, so no wrap beyond it is possible. period = 2^WIDTH−1 is legal.
- Changing the period or mode inputs while in RUN has no effect until the next start.

## Timing
- Reset values: all outputs and internal state are 0; every channel is IDLE.
- The reset is asynchronous. Asserting it mid-run clears tick, busy and count immediately, without waiting for a clock edge.
- Start sampled at edge 0 with en held high:
  - busy = 1 after edge 0.
  - count = k after edge k, for k ≤ P.
  - tick = 1 for the single cycle after edge P+1.
- Periodic tick spacing is exactly P+1 enabled cycles. Paused cycles stretch the spacing one-for-one.
- One-shot: busy falls on the same edge that raises tick, so both change together.
- Latency from start to first tick is P+1 edges; there is no extra pipeline stage.

## Structure
- Package tick_pkg:
  - typedef enum logic {TICK_PERIODIC = 1'b0, TICK_ONESHOT = 1'b1} tick_mode_t.
  - typedef enum logic {CH_IDLE, CH_RUN} ch_state_t.
- Sub-module tick_channel: a single channel with a WIDTH parameter, containing the FSM, counter and period/mode latches.
- tick_gen instantiates NUM_CH copies of tick_channel in a generate loop and has no logic of its own apart from port slicing.

## Test plan
- Periodic, NUM_CH=4, WIDTH=8, ch0 period=3, en=1: tick0 pulses after edges 4, 8 and 12. The count sequence is 0,1,2,3,0; busy0 stays high.
- One-shot on ch1 with period=5: a single tick after edge 6. busy1 falls on the same edge, and no further ticks follow within the next 20 cycles.
- Pause: ch0 periodic with period=3 and en low for 2 cycles mid-count. Count holds its value during the pause and the next tick arrives 2 cycles late. No tick appears while en=0.
- Restart and collisions:
  - start on ch2 at count=2 of period 7, with new period=1: count → 0, then ticks every 2 cycles.
  - start and stop together on ch2: busy2 = 0 and count2 = 0.
- Edge values:
  - period=0 periodic: tick high every cycle.
  - period=0 one-shot: exactly one tick.
  - period=255 with WIDTH=8: tick after edge 256, with no overflow.
- Reset mid-run: assert RST between clock edges while all channels are busy. All outputs go to 0 before the next edge, and nothing ticks until a new start.
